ps2_key_rx: RTL

- PS/2 keyboard receiver (host/device-to-host end of the PS/2 link) that gives the dinosaur game keyboard control alongside the debounced button path.
- Samples ps2_clk/ps2_data, assembles 11-bit frames, checks parity and framing, and tracks scan-code set 2 make/break prefixes.
- Outputs a held jump level, a one-shot jump pulse and a one-shot restart request to statereg's input side, plus raw byte taps for debug.

---
 rtl/ps2_key_rx.sv | 110 +++++++++++
 1 files changed

// File: rtl/ps2_key_rx.sv
// ps2_key_rx: PS/2 keyboard receiver decoding set-2 make/break codes into jump and restart controls.
module ps2_key_rx #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT_CYC = 200000,
  parameter logic [7:0] JUMP_CODE = 8'h29,
  parameter logic [7:0] RESTART_CODE = 8'h5A
) (
  input  logic       clk,
  input  logic       restart,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scan_code,
  output logic       code_valid,
  output logic       frame_err,
  output logic       jump,
  output logic       jump_pulse,
  output logic       restart_key
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t state, state_nx;
  logic [1:0] clk_s, dat_s;
  logic flt, flt_d, fall, timeout, done, good, is_brk, is_ext, key_map;
  logic jump_set, jump_clr, rst_hit, brk, ext, par;
  logic [FW-1:0] fcnt;
  logic [TW-1:0] tcnt;
  logic [2:0] bcnt;
  logic [7:0] sh;
  // the filtered clock only follows the synchronized line after FILTER_LEN disagreeing samples in a row
  always_ff @(posedge clk or negedge restart)
    if (!restart) begin
      clk_s <= '1;
      dat_s <= '1;
      flt   <= 1'b1;
      flt_d <= 1'b1;
      fcnt  <= '0;
    end else begin
      clk_s <= {clk_s[0], ps2_clk};
      dat_s <= {dat_s[0], ps2_data};
      flt_d <= flt;
      if (clk_s[1] == flt) fcnt <= '0;
      else if (fcnt == FW'(FILTER_LEN - 1)) begin
        flt  <= clk_s[1];
        fcnt <= '0;
      end else fcnt <= fcnt + 1'b1;
    end
  assign fall = flt_d & ~flt;
  assign timeout = (state != IDLE) && !fall && (tcnt == TW'(TIMEOUT_CYC - 1));
  always_ff @(posedge clk or negedge restart)
    if (!restart) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    if (timeout) state_nx = IDLE;
    else if (fall)
      case (state)
        IDLE:    state_nx = dat_s[1] ? IDLE : DATA;
        DATA:    state_nx = (bcnt == 3'd7) ? PARITY : DATA;
        PARITY:  state_nx = STOP;
        default: state_nx = IDLE;
      endcase
  end
  always_comb begin
    done     = fall && (state == STOP);
    good     = dat_s[1] && ^{sh, par};
    is_brk   = sh == 8'hF0;
    is_ext   = sh == 8'hE0;
    key_map  = done && good && !is_brk && !is_ext && !ext;
    jump_set = key_map && (sh == JUMP_CODE) && !brk;
    jump_clr = key_map && (sh == JUMP_CODE) && brk;
    rst_hit  = key_map && (sh == RESTART_CODE) && !brk;
  end
  always_ff @(posedge clk or negedge restart)
    if (!restart) begin
      tcnt <= '0;
      bcnt <= '0;
      sh   <= '0;
      par  <= 1'b0;
    end else begin
      tcnt <= (state == IDLE || fall || timeout) ? '0 : tcnt + 1'b1;
      if (fall && state == IDLE) bcnt <= '0;
      if (fall && state == DATA) begin
        sh   <= {dat_s[1], sh[7:1]};
        bcnt <= bcnt + 1'b1;
      end
      if (fall && state == PARITY) par <= dat_s[1];
    end
  // prefixes only set their own flag; a key byte, bad frame or timeout clears both
  always_ff @(posedge clk or negedge restart)
    if (!restart) begin
      scan_code   <= '0;
      code_valid  <= 1'b0;
      frame_err   <= 1'b0;
      jump        <= 1'b0;
      jump_pulse  <= 1'b0;
      restart_key <= 1'b0;
      brk         <= 1'b0;
      ext         <= 1'b0;
    end else begin
      code_valid  <= done && good;
      frame_err   <= (done && !good) || timeout;
      jump_pulse  <= jump_set && !jump;
      restart_key <= rst_hit;
      if (done && good) scan_code <= sh;
      jump <= jump_set ? 1'b1 : jump_clr ? 1'b0 : jump;
      brk  <= (done && good) ? (is_brk | (is_ext & brk)) : (done || timeout) ? 1'b0 : brk;
      ext  <= (done && good) ? (is_ext | (is_brk & ext)) : (done || timeout) ? 1'b0 : ext;
    end
endmodule
